// File: rtl/id_stage_if.sv
// Bundles the IF/ID, status and write-back inputs with the ID/EX outputs of id_stage.
// master drives the stage inputs; slave is the decode stage itself.
interface id_stage_if;
    logic [31:0] PC_in;
    logic [31:0] Inst;
    logic [3:0]  SR;
    logic        hazard;
    logic        WB_WB_EN;
    logic [3:0]  WB_Dest;
    logic [31:0] WB_Value;

    logic [31:0] PC;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        B;
    logic        S;
    logic [3:0]  EXE_CMD;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  Dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        Two_src;

    modport master (
        output PC_in, Inst, SR, hazard, WB_WB_EN, WB_Dest, WB_Value,
        input  PC, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, Val_Rn, Val_Rm,
               imm, Shift_operand, Signed_imm_24, Dest, src1, src2, Two_src
    );

    modport slave (
        input  PC_in, Inst, SR, hazard, WB_WB_EN, WB_Dest, WB_Value,
        output PC, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, Val_Rn, Val_Rm,
               imm, Shift_operand, Signed_imm_24, Dest, src1, src2, Two_src
    );
endinterface

// File: rtl/id_stage.sv
// ARM decode stage: register file read, control decode, condition check, write-back port.
// Optional macro ID_RF_BYPASS_EN forwards a same-cycle write-back to the read ports.
module id_stage (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);
    localparam int unsigned NUM_REGS = 15;
    localparam int unsigned DATA_W   = 32;
    localparam logic [3:0]  PC_IDX   = 4'd15;

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic [3:0] cond;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic [3:0] rs2;

    logic [3:0] exe_raw;
    logic       wb_raw;
    logic       mr_raw;
    logic       mw_raw;
    logic       b_raw;
    logic       s_raw;
    logic       cond_ok;
    logic       kill;
    logic       n_f, z_f, c_f, v_f;

    assign cond   = bus.Inst[31:28];
    assign mode   = bus.Inst[27:26];
    assign i_bit  = bus.Inst[25];
    assign opcode = bus.Inst[24:21];
    assign s_bit  = bus.Inst[20];
    assign rn     = bus.Inst[19:16];
    assign rd     = bus.Inst[15:12];
    assign rm     = bus.Inst[3:0];
    assign {n_f, z_f, c_f, v_f} = bus.SR;

    // Register file: reset seeds R[i] = i; index 15 is the PC and never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= DATA_W'(i);
            end
        end else if (bus.WB_WB_EN && bus.WB_Dest != PC_IDX) begin
            rf[bus.WB_Dest] <= bus.WB_Value;
        end
    end

    // Raw control decode, before any bubble is applied.
    always_comb begin
        exe_raw = 4'd0;
        wb_raw  = 1'b0;
        mr_raw  = 1'b0;
        mw_raw  = 1'b0;
        b_raw   = 1'b0;
        s_raw   = 1'b0;
        unique case (mode)
            2'b00: begin
                wb_raw = 1'b1;
                s_raw  = s_bit;
                case (opcode)
                    4'b1101: exe_raw = 4'b0001;
                    4'b1111: exe_raw = 4'b1001;
                    4'b0100: exe_raw = 4'b0010;
                    4'b0101: exe_raw = 4'b0011;
                    4'b0010: exe_raw = 4'b0100;
                    4'b0110: exe_raw = 4'b0101;
                    4'b0000: exe_raw = 4'b0110;
                    4'b1100: exe_raw = 4'b0111;
                    4'b0001: exe_raw = 4'b1000;
                    4'b1010: begin exe_raw = 4'b0100; wb_raw = 1'b0; end
                    4'b1000: begin exe_raw = 4'b0110; wb_raw = 1'b0; end
                    default: begin wb_raw = 1'b0; s_raw = 1'b0; end
                endcase
            end
            2'b01: begin
                exe_raw = 4'b0010;
                if (s_bit) begin
                    mr_raw = 1'b1;
                    wb_raw = 1'b1;
                end else begin
                    mw_raw = 1'b1;
                end
            end
            2'b10: b_raw = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = ~z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = ~c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = ~n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = ~v_f;
            4'b1000: cond_ok = c_f & ~z_f;
            4'b1001: cond_ok = ~c_f | z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = ~z_f & (n_f == v_f);
            4'b1101: cond_ok = z_f | (n_f != v_f);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign kill = bus.hazard | ~cond_ok;
    // Store reads its data register through the second port, so src2 follows raw MEM_W_EN.
    assign rs2  = mw_raw ? rd : rm;

    always_comb begin
        bus.WB_EN    = wb_raw & ~kill;
        bus.MEM_R_EN = mr_raw & ~kill;
        bus.MEM_W_EN = mw_raw & ~kill;
        bus.B        = b_raw & ~kill;
        bus.S        = s_raw & ~kill;
        bus.EXE_CMD  = kill ? 4'd0 : exe_raw;
    end

    always_comb begin
        bus.Val_Rn = '0;
        bus.Val_Rm = '0;
        if (rn != PC_IDX) bus.Val_Rn = rf[rn];
        if (rs2 != PC_IDX) bus.Val_Rm = rf[rs2];
`ifdef ID_RF_BYPASS_EN
        if (bus.WB_WB_EN && bus.WB_Dest != PC_IDX && bus.WB_Dest == rn)  bus.Val_Rn = bus.WB_Value;
        if (bus.WB_WB_EN && bus.WB_Dest != PC_IDX && bus.WB_Dest == rs2) bus.Val_Rm = bus.WB_Value;
`endif
    end

    assign bus.PC            = bus.PC_in;
    assign bus.imm           = i_bit;
    assign bus.Shift_operand = bus.Inst[11:0];
    assign bus.Signed_imm_24 = bus.Inst[23:0];
    assign bus.Dest          = rd;
    assign bus.src1          = rn;
    assign bus.src2          = rs2;
    assign bus.Two_src       = ~i_bit | mw_raw;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand sequences, and
// randomized stimulus against a behavioural decode/register-file model.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    id_stage_if bus ();

    id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_rf [15];

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  sr;
        logic        hz;
        logic [3:0]  exe;
        logic        wb, mr, mw, b, s, two;
        logic [3:0]  src2;
    } vec_t;

    typedef struct {
        logic [3:0] exe;
        logic       wb, mr, mw, b, s, two;
        logic [3:0] src2;
    } exp_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model: ALU command per data-processing opcode; -1 marks an undefined opcode.
    function automatic int alu_of(input logic [3:0] op);
        int tbl[16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
        return tbl[op];
    endfunction

    function automatic exp_t model(input logic [31:0] inst, input logic [3:0] sr, input logic hz);
        exp_t e;
        int   cmd;
        logic store;
        e = '{default: '0};
        cmd = alu_of(inst[24:21]);
        store = (inst[27:26] == 2'b01) && !inst[20];
        if (inst[27:26] == 2'b00 && cmd >= 0) begin
            e.exe = 4'(cmd);
            e.wb  = !(inst[24:21] == 4'b1010 || inst[24:21] == 4'b1000);
            e.s   = inst[20];
        end else if (inst[27:26] == 2'b01) begin
            e.exe = 4'd2;
            e.mr  = inst[20];
            e.wb  = inst[20];
            e.mw  = !inst[20];
        end else if (inst[27:26] == 2'b10) begin
            e.b = 1'b1;
        end
        if (hz || !cond_holds(inst[31:28], sr)) begin
            e.exe = 4'd0; e.wb = 0; e.mr = 0; e.mw = 0; e.b = 0; e.s = 0;
        end
        e.src2 = store ? inst[15:12] : inst[3:0];
        e.two  = !inst[25] || store;
        return e;
    endfunction

    function automatic logic [31:0] rf_read(input logic [3:0] idx);
        logic [31:0] v;
        v = (idx == 4'd15) ? 32'd0 : ref_rf[idx];
`ifdef ID_RF_BYPASS_EN
        if (bus.WB_WB_EN && bus.WB_Dest == idx && idx != 4'd15) v = bus.WB_Value;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) ref_rf[i] = 32'(i);
    endtask

    task automatic model_clock();
        if (bus.WB_WB_EN && bus.WB_Dest != 4'd15) ref_rf[bus.WB_Dest] = bus.WB_Value;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [3:0] sr, input logic hz);
        bus.Inst = inst; bus.SR = sr; bus.hazard = hz;
        #1;
    endtask

    task automatic check_full(input string tag);
        exp_t e;
        e = model(bus.Inst, bus.SR, bus.hazard);
        chk({tag, ".EXE_CMD"},  32'(bus.EXE_CMD),  32'(e.exe));
        chk({tag, ".ctrl"},     32'({bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.B, bus.S}),
                                32'({e.wb, e.mr, e.mw, e.b, e.s}));
        chk({tag, ".src"},      32'({bus.src1, bus.src2, bus.Two_src}),
                                32'({bus.Inst[19:16], e.src2, e.two}));
        chk({tag, ".Val_Rn"},   bus.Val_Rn, rf_read(bus.Inst[19:16]));
        chk({tag, ".Val_Rm"},   bus.Val_Rm, rf_read(e.src2));
        chk({tag, ".fields"},   32'({bus.imm, bus.Dest, bus.Signed_imm_24}),
                                32'({bus.Inst[25], bus.Inst[15:12], bus.Inst[23:0]}));
        chk({tag, ".Shift"},    32'(bus.Shift_operand), 32'(bus.Inst[11:0]));
        chk({tag, ".PC"},       bus.PC, bus.PC_in);
    endtask

    initial begin
        bus.PC_in = 32'h0000_0004; bus.Inst = '0; bus.SR = '0; bus.hazard = 1'b0;
        bus.WB_WB_EN = 1'b0; bus.WB_Dest = '0; bus.WB_Value = '0;
        model_reset();

        vecs[0]  = '{32'hE1A00001, 4'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1};
        vecs[1]  = '{32'hE0832004, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4};
        vecs[2]  = '{32'hE5817000, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7};
        vecs[3]  = '{32'hE5817000, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7};
        vecs[4]  = '{32'hE5917000, 4'h0, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        vecs[5]  = '{32'h0A000010, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[6]  = '{32'h0A000010, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[7]  = '{32'hE3510005, 4'h0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5};
        vecs[8]  = '{32'hC1100002, 4'h0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2};
        vecs[9]  = '{32'hE0600000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        vecs[10] = '{32'hEC000000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        vecs[11] = '{32'hF1A00001, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1};
        vecs[12] = '{32'hB0832004, 4'h8, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4};
        vecs[13] = '{32'h10D32004, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4};

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset contents R[i] = i, and index 15 reads zero.
        for (int i = 0; i < 16; i++) begin
            drive({4'hE, 8'h08, 4'(i), 4'h2, 8'h00, 4'(i)}, 4'h0, 1'b0);
            chk($sformatf("reset.R%0d.Rn", i), bus.Val_Rn, (i == 15) ? 32'd0 : 32'(i));
            chk($sformatf("reset.R%0d.Rm", i), bus.Val_Rm, (i == 15) ? 32'd0 : 32'(i));
        end

        for (int k = 0; k < 14; k++) begin
            drive(vecs[k].inst, vecs[k].sr, vecs[k].hz);
            chk($sformatf("vec%0d.EXE_CMD", k), 32'(bus.EXE_CMD), 32'(vecs[k].exe));
            chk($sformatf("vec%0d.ctrl", k),
                32'({bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.B, bus.S}),
                32'({vecs[k].wb, vecs[k].mr, vecs[k].mw, vecs[k].b, vecs[k].s}));
            chk($sformatf("vec%0d.Two_src", k), 32'(bus.Two_src), 32'(vecs[k].two));
            chk($sformatf("vec%0d.src2", k), 32'(bus.src2), 32'(vecs[k].src2));
            chk($sformatf("vec%0d.Val_Rm", k), bus.Val_Rm, 32'(vecs[k].src2));
            chk($sformatf("vec%0d.Signed_imm_24", k), 32'(bus.Signed_imm_24), 32'(vecs[k].inst[23:0]));
        end

        // Write R3, then ADD R2,R3,R4 sees it after the edge.
        @(negedge clk);
        bus.WB_WB_EN = 1'b1; bus.WB_Dest = 4'd3; bus.WB_Value = 32'hDEAD_BEEF;
        @(posedge clk); model_clock();
        @(negedge clk); bus.WB_WB_EN = 1'b0;
        drive(32'hE0832004, 4'h0, 1'b0);
        chk("wb_r3.Val_Rn", bus.Val_Rn, 32'hDEAD_BEEF);
        chk("wb_r3.Val_Rm", bus.Val_Rm, 32'd4);
        chk("wb_r3.EXE_CMD", 32'(bus.EXE_CMD), 32'd2);

        // Same-cycle write and read of R5.
        @(negedge clk);
        bus.WB_WB_EN = 1'b1; bus.WB_Dest = 4'd5; bus.WB_Value = 32'h55;
        drive(32'hE0852004, 4'h0, 1'b0);
`ifdef ID_RF_BYPASS_EN
        chk("same_cycle.Val_Rn", bus.Val_Rn, 32'h55);
`else
        chk("same_cycle.Val_Rn", bus.Val_Rn, 32'd5);
`endif
        @(posedge clk); model_clock();
        @(negedge clk); bus.WB_WB_EN = 1'b0;
        #1;
        chk("after_edge.Val_Rn", bus.Val_Rn, 32'h55);

        // Write to index 15 is dropped and index 15 still reads zero.
        @(negedge clk);
        bus.WB_WB_EN = 1'b1; bus.WB_Dest = 4'd15; bus.WB_Value = 32'h1234;
        @(posedge clk); model_clock();
        @(negedge clk); bus.WB_WB_EN = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive({4'hE, 8'h08, 4'(i), 4'h2, 12'h000}, 4'h0, 1'b0);
            chk($sformatf("r15_drop.R%0d", i), bus.Val_Rn, ref_rf[i]);
        end
        drive(32'hE08F200F, 4'h0, 1'b0);
        chk("r15_read.Val_Rn", bus.Val_Rn, 32'd0);
        chk("r15_read.Val_Rm", bus.Val_Rm, 32'd0);

        // Reset asserted across a write edge: the write is lost.
        @(negedge clk);
        bus.WB_WB_EN = 1'b1; bus.WB_Dest = 4'd6; bus.WB_Value = 32'hAAAA_AAAA;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.WB_WB_EN = 1'b0;
        model_reset();
        drive(32'hE0862003, 4'h0, 1'b0);
        chk("rst_write.R6", bus.Val_Rn, 32'd6);
        chk("rst_write.R3", bus.Val_Rm, 32'd3);

        // Randomized stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            bus.PC_in    = $urandom;
            bus.WB_WB_EN = 1'($urandom_range(0, 1));
            bus.WB_Dest  = 4'($urandom_range(0, 15));
            bus.WB_Value = $urandom;
            drive($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
            check_full($sformatf("rand%0d", n));
            @(posedge clk); model_clock();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
